// File: rtl/display_scheduler.sv
// Two-requester arbiter for the shared 6-digit BCD display, with a minimum hold
// window per grant, digit scan multiplexing and error-mode blinking.
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [11:0] val_a,
  input  logic        req_b,
  input  logic [11:0] val_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy,
  output logic [11:0] disp_val,
  input  logic [3:0]  bcd5,
  input  logic [3:0]  bcd4,
  input  logic [3:0]  bcd3,
  input  logic [3:0]  bcd2,
  input  logic [3:0]  bcd1,
  input  logic [3:0]  bcd0,
  output logic [5:0]  digit_sel,
  output logic [3:0]  digit_bcd
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = $clog2(2 * BLINK_FRAMES);

  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(SCAN_DIV - 1);

  typedef enum logic {StIdle, StShow} state_e;

  state_e             state_q;
  logic [HoldW-1:0]   hold_q;
  logic               last_b_q;

  logic               grant;
  logic               pick_b;
  logic [11:0]        disp_d;

  // B has priority unless A is also waiting and B won the previous round.
  assign grant  = (state_q == StIdle) && (req_a || req_b);
  assign pick_b = req_b && !(req_a && last_b_q);
  assign disp_d = grant ? (pick_b ? val_b : val_a) : disp_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      last_b_q <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      busy     <= 1'b0;
      disp_val <= 12'h800;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant) begin
            state_q  <= StShow;
            busy     <= 1'b1;
            hold_q   <= HoldLoad;
            disp_val <= disp_d;
            last_b_q <= pick_b;
            gnt_b    <= pick_b;
            gnt_a    <= !pick_b;
          end
        end
        StShow: begin
          if (hold_q == '0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        idx_q, idx_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              blank;
  logic [5:0]        sel_d;
  logic [3:0]        bcd_d;

  always_comb begin
    div_d   = div_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (div_q == DivLast) begin
      div_d = '0;
      if (idx_q == 3'd5) begin
        idx_d   = 3'd0;
        frame_d = frame_q + 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // Outputs are computed from next-state so digit_sel/digit_bcd always agree
  // with the registered index, frame and displayed word.
  always_comb begin
    blank = (disp_d[11:10] == 2'b11) && frame_d[FrameW-1];
    sel_d = blank ? 6'b000000 : (6'b100000 >> idx_d);
    case (idx_d)
      3'd0:    bcd_d = bcd5;
      3'd1:    bcd_d = bcd4;
      3'd2:    bcd_d = bcd3;
      3'd3:    bcd_d = bcd2;
      3'd4:    bcd_d = bcd1;
      3'd5:    bcd_d = bcd0;
      default: bcd_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      idx_q     <= 3'd0;
      frame_q   <= '0;
      digit_sel <= 6'b100000;
      digit_bcd <= 4'h0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      digit_sel <= sel_d;
      digit_bcd <= bcd_d;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: arbitration vector table, scan/blink/reset
// sequences, and randomized traffic against a cycle-count reference model.
module tb_display_scheduler;

  localparam int HOLD = 4;
  localparam int SD   = 2;
  localparam int BF   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a, req_b;
  logic [11:0] val_a, val_b;
  logic        gnt_a, gnt_b, busy;
  logic [11:0] disp_val;
  logic [3:0]  bcd5, bcd4, bcd3, bcd2, bcd1, bcd0;
  logic [5:0]  digit_sel;
  logic [3:0]  digit_bcd;

  int passed = 0;
  int total  = 0;

  display_scheduler #(
    .HOLD_CYCLES  (HOLD),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .val_a     (val_a),
    .req_b     (req_b),
    .val_b     (val_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .busy      (busy),
    .disp_val  (disp_val),
    .bcd5      (bcd5),
    .bcd4      (bcd4),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .digit_sel (digit_sel),
    .digit_bcd (digit_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ra;
    logic        rb;
    logic [11:0] va;
    logic [11:0] vb;
    logic        ga;
    logic        gb;
    logic        bz;
    logic [11:0] dv;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; val_a = '0; val_b = '0;
    bcd5 = '0; bcd4 = '0; bcd3 = '0; bcd2 = '0; bcd1 = '0; bcd0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " disp_val"}, 32'(disp_val), 32'h800);
    check({tag, " digit_sel"}, 32'(digit_sel), 32'h20);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " gnt"}, {30'h0, gnt_a, gnt_b}, 32'h0);
    check({tag, " digit_bcd"}, 32'(digit_bcd), 32'h0);
  endtask

  // Reference model: everything derived from the edge count since reset release.
  int          m_n, m_free, m_grant_end;
  logic        m_last_b, m_ga, m_gb;
  logic [11:0] m_disp;

  task automatic model_init();
    m_n = 0; m_free = 1; m_grant_end = 0;
    m_last_b = 1'b0; m_ga = 1'b0; m_gb = 1'b0; m_disp = 12'h800;
  endtask

  task automatic model_edge(input logic ra, input logic rb, input logic [11:0] va,
                            input logic [11:0] vb, input logic [3:0] bv[6],
                            output logic bz, output logic [5:0] sel, output logic [3:0] dig);
    int idx, frame;
    m_n++;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (m_n >= m_free && (ra || rb)) begin
      if (rb && !(ra && m_last_b)) begin
        m_gb = 1'b1; m_disp = vb; m_last_b = 1'b1;
      end else begin
        m_ga = 1'b1; m_disp = va; m_last_b = 1'b0;
      end
      m_grant_end = m_n + HOLD;
      m_free      = m_n + HOLD + 1;
    end
    bz    = (m_n < m_grant_end);
    idx   = (m_n / SD) % 6;
    frame = (m_n / (6 * SD)) % (2 * BF);
    dig   = bv[5 - idx];
    sel   = (m_disp[11:10] == 2'b11 && frame >= BF) ? 6'b000000 : (6'b100000 >> idx);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 12'h000, 12'h123, 1'b0, 1'b1, 1'b1, 12'h123};
    tbl[1]  = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h123};
    tbl[2]  = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h123};
    tbl[3]  = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h123};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12'h123};
    tbl[5]  = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b1, 1'b0, 1'b1, 12'h456};
    tbl[6]  = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b1, 12'h456};
    tbl[7]  = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b1, 12'h456};
    tbl[8]  = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b1, 12'h456};
    tbl[9]  = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b0, 12'h456};
    tbl[10] = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b1, 1'b1, 12'h789};
    tbl[11] = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b1, 12'h789};
    tbl[12] = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b1, 12'h789};
    tbl[13] = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b1, 12'h789};
    tbl[14] = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b0, 1'b0, 1'b0, 12'h789};
    tbl[15] = '{1'b1, 1'b1, 12'h456, 12'h789, 1'b1, 1'b0, 1'b1, 12'h456};
    tbl[16] = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h456};
    tbl[17] = '{1'b1, 1'b0, 12'hAAA, 12'h000, 1'b0, 1'b0, 1'b1, 12'h456};
    tbl[18] = '{1'b1, 1'b0, 12'hAAA, 12'h000, 1'b0, 1'b0, 1'b1, 12'h456};
    tbl[19] = '{1'b1, 1'b0, 12'hAAA, 12'h000, 1'b0, 1'b0, 1'b0, 12'h456};
    tbl[20] = '{1'b1, 1'b0, 12'hAAA, 12'h000, 1'b1, 1'b0, 1'b1, 12'hAAA};
    tbl[21] = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'hAAA};

    // Reset values, then arbitration table.
    do_reset();
    check_reset_vals("reset");
    for (int i = 0; i < 22; i++) begin
      req_a = tbl[i].ra; req_b = tbl[i].rb; val_a = tbl[i].va; val_b = tbl[i].vb;
      step();
      check($sformatf("tbl[%0d] gnt_a", i), 32'(gnt_a), 32'(tbl[i].ga));
      check($sformatf("tbl[%0d] gnt_b", i), 32'(gnt_b), 32'(tbl[i].gb));
      check($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(tbl[i].bz));
      check($sformatf("tbl[%0d] disp_val", i), 32'(disp_val), 32'(tbl[i].dv));
    end

    // Static digits 1..6: two cycles per digit, left to right, wrapping.
    do_reset();
    bcd5 = 4'd1; bcd4 = 4'd2; bcd3 = 4'd3; bcd2 = 4'd4; bcd1 = 4'd5; bcd0 = 4'd6;
    for (int n = 1; n <= 26; n++) begin
      int idx;
      step();
      idx = (n / 2) % 6;
      check($sformatf("scan n=%0d digit_bcd", n), 32'(digit_bcd), 32'(idx + 1));
      check($sformatf("scan n=%0d digit_sel", n), 32'(digit_sel), 32'(6'b100000 >> idx));
    end

    // Error-mode word: two frames lit, two frames blank.
    do_reset();
    bcd5 = 4'd9; bcd4 = 4'd8; bcd3 = 4'd7; bcd2 = 4'd6; bcd1 = 4'd5; bcd0 = 4'd4;
    req_b = 1'b1; val_b = 12'hC00;
    for (int n = 1; n <= 60; n++) begin
      int frame;
      step();
      if (n == 1) begin
        check("blink grant", {30'h0, gnt_a, gnt_b}, 32'h1);
        req_b = 1'b0;
      end
      frame = (n / 12) % 4;
      check($sformatf("blink n=%0d digit_sel", n), 32'(digit_sel),
            (frame >= 2) ? 32'h0 : 32'(6'b100000 >> ((n / 2) % 6)));
    end
    check("blink disp_val", 32'(disp_val), 32'hC00);

    // Reset asserted mid-hold wipes everything; nothing is granted afterwards.
    do_reset();
    req_a = 1'b1; val_a = 12'h321;
    step();
    check("midhold grant", 32'(gnt_a), 32'h1);
    req_a = 1'b0;
    step();
    step();
    check("midhold busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midhold reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-reset busy", 32'(busy), 32'h0);
    check("post-reset gnt", {30'h0, gnt_a, gnt_b}, 32'h0);
    check("post-reset disp_val", 32'(disp_val), 32'h800);

    // Randomized traffic against the reference model.
    do_reset();
    model_init();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] bv[6];
      logic       e_bz;
      logic [5:0] e_sel;
      logic [3:0] e_dig;
      req_a = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      val_a = 12'($urandom);
      val_b = ($urandom_range(0, 2) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      bcd0 = 4'($urandom_range(0, 9)); bcd1 = 4'($urandom_range(0, 9));
      bcd2 = 4'($urandom_range(0, 9)); bcd3 = 4'($urandom_range(0, 9));
      bcd4 = 4'($urandom_range(0, 9)); bcd5 = 4'($urandom_range(0, 9));
      bv[0] = bcd0; bv[1] = bcd1; bv[2] = bcd2; bv[3] = bcd3; bv[4] = bcd4; bv[5] = bcd5;
      step();
      model_edge(req_a, req_b, val_a, val_b, bv, e_bz, e_sel, e_dig);
      check($sformatf("rand c=%0d gnt_a", c), 32'(gnt_a), 32'(m_ga));
      check($sformatf("rand c=%0d gnt_b", c), 32'(gnt_b), 32'(m_gb));
      check($sformatf("rand c=%0d busy", c), 32'(busy), 32'(e_bz));
      check($sformatf("rand c=%0d disp_val", c), 32'(disp_val), 32'(m_disp));
      check($sformatf("rand c=%0d digit_sel", c), 32'(digit_sel), 32'(e_sel));
      check($sformatf("rand c=%0d digit_bcd", c), 32'(digit_bcd), 32'(e_dig));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
